// File: rtl/mips_defs.sv
// mips_defs: shared widths, memory sizing and memory-op decode for the MIPS pipeline.
package mips_defs;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = 16;

    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_ADDI = 6'h08;

    typedef enum logic [1:0] {MEM_NONE, MEM_LOAD, MEM_STORE, MEM_BAD} mem_op_e;

    function automatic mem_op_e mem_decode(input logic rd, input logic wr);
        return (rd & wr) ? MEM_BAD : rd ? MEM_LOAD : wr ? MEM_STORE : MEM_NONE;
    endfunction
endpackage

// File: rtl/data_mem.sv
// data_mem: word-addressed data memory, synchronous write and asynchronous read.
module data_mem
    import mips_defs::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] Data_MEM [DEPTH];

    always_ff @(posedge clk)
        if (we) Data_MEM[addr] <= wdata;

    assign rdata = Data_MEM[addr];
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MIPS MEM stage with data memory, MEM/WB register, LW/SW counters and fault flag.
module mem_wb_stage
    import mips_defs::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  load_count,
    output logic [CNT_W-1:0]  store_count,
    output logic              addr_fault
);
    mem_op_e           op;
    logic              active;
    logic              in_range;
    logic              is_load;
    logic              is_store;
    logic              store_en;
    logic              fault_now;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] next_data;

    always_comb begin
        op        = mem_decode(ex_mem_read, ex_mem_write);
        active    = ex_valid & ~stall;
        in_range  = ex_alu_result < DATA_W'(DEPTH);
        is_load   = op == MEM_LOAD;
        is_store  = op == MEM_STORE;
        // reset gates the enable so a store racing an async reset is dropped
        store_en  = active & is_store & in_range & ~reset;
        fault_now = active & ((op == MEM_BAD) | ((is_load | is_store) & ~in_range));
        next_data = is_load ? (in_range ? rdata : '0) : (op == MEM_BAD) ? '0 : ex_alu_result;
    end

    data_mem D_Mem (
        .clk   (clk),
        .we    (store_en),
        .addr  (ex_alu_result[ADDR_W-1:0]),
        .wdata (ex_store_data),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            load_count   <= '0;
            store_count  <= '0;
            addr_fault   <= 1'b0;
        end else if (!stall) begin
            wb_valid     <= ex_valid;
            wb_reg_write <= ex_valid & ex_reg_write & (ex_rd != '0) & (op != MEM_BAD);
            if (ex_valid) begin
                wb_rd   <= ex_rd;
                wb_data <= next_data;
            end
            if (fault_now) addr_fault <= 1'b1;
            if (active && is_load && !(&load_count)) load_count <= load_count + 1'b1;
            if (active && is_store && !(&store_count)) store_count <= store_count + 1'b1;
        end
    end
endmodule
